// File: rtl/sum10_operand_loader.sv
// sum10_operand_loader
// Feeds the ten-operand carry-save adder tree. Bytes arrive one per handshake
// and are packed into a zero-padded frame on the ops bus. Once the frame is
// complete, ops_valid is held for one cycle while the adder's combinational sum
// is captured. The captured sum and operand count are then held for a
// downstream consumer until it accepts them.
//
// Handshake rules (valid/ready on both sides):
//   A transfer happens at a rising edge where valid && ready are both high.
//   Once valid is raised, the producer holds it and its data steady until that
//   edge. Ready may depend on state, but never on valid in the same cycle.
//   in_valid is ignored while in_ready=0 (CAPTURE/DONE). The byte is not lost;
//   it is taken once the loader is back in FILL.

module sum10_operand_loader #(
    parameter int NOPS = 10,
    parameter int W    = 8,
    parameter int SW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic              in_last,
    output logic [NOPS*W-1:0] ops,
    output logic              ops_valid,
    input  logic [SW-1:0]     sum_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     out_sum,
    output logic [3:0]        out_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    // Slot index of the next byte in FILL. On the final byte it is left
    // pointing at that byte, so the operand count is r_cnt + 1.
    logic [3:0]         r_cnt;
    logic [NOPS*W-1:0]  r_ops;
    logic [SW-1:0]      r_sum;
    logic [3:0]         r_count;

    logic               w_accept;
    logic               w_frame_end;
    logic               w_release;

    // Handshake qualifiers decoded from the state flop
    assign w_accept    = in_valid && (r_state == S_FILL);
    assign w_frame_end = in_last || (r_cnt == 4'(NOPS - 1));
    assign w_release   = out_ready && (r_state == S_DONE);

    // Frame FSM: fills slots, captures the adder sum, and holds the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_cnt   <= 4'd0;
            r_ops   <= '0;
            r_sum   <= '0;
            r_count <= 4'd0;
        end else if (flush) begin
            // Abort the frame. Any held result is dropped by leaving DONE;
            // out_sum/out_count are simply not valid any more.
            r_state <= S_FILL;
            r_cnt   <= 4'd0;
            r_ops   <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < NOPS; i++) begin
                            if (r_cnt == 4'(i)) begin
                                r_ops[i*W +: W] <= in_data;
                            end
                        end
                        if (w_frame_end) begin
                            r_state <= S_CAPTURE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_sum   <= sum_in;
                    r_count <= r_cnt + 4'd1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (w_release) begin
                        r_state <= S_FILL;
                        r_cnt   <= 4'd0;
                        r_ops   <= '0;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                    r_cnt   <= 4'd0;
                    r_ops   <= '0;
                end
            endcase
        end
    end

    // Outputs: registered values, plus handshake flags decoded from state
    assign in_ready  = (r_state == S_FILL);
    assign ops_valid = (r_state == S_CAPTURE);
    assign out_valid = (r_state == S_DONE);
    assign ops       = r_ops;
    assign out_sum   = r_sum;
    assign out_count = r_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sum10_operand_loader.sv
// Directed bench for sum10_operand_loader. The adder tree is modelled here as a
// plain sum of the ten operand slots and is looped back into sum_in.
module tb_sum10_operand_loader;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [79:0] ops;
  logic        ops_valid;
  logic [15:0] sum_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [3:0]  out_count;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  logic [7:0]  fb [10];
  logic [15:0] exp_q [$];

  sum10_operand_loader #(.NOPS(10), .W(8), .SW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .ops       (ops),
    .ops_valid (ops_valid),
    .sum_in    (sum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  // clock / adder model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sum_in = '0;
    for (int i = 0; i < 10; i++) sum_in = sum_in + 16'(ops[i*8 +: 8]);
  end

  // checking task
  task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [79:0] pack_ops(input int n);
    logic [79:0] e;
    e = '0;
    for (int i = 0; i < n; i++) e[i*8 +: 8] = fb[i];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_fb(input int b0, input int b1, input int b2, input int b3, input int b4,
                         input int b5, input int b6, input int b7, input int b8, input int b9);
    fb[0] = 8'(b0); fb[1] = 8'(b1); fb[2] = 8'(b2); fb[3] = 8'(b3); fb[4] = 8'(b4);
    fb[5] = 8'(b5); fb[6] = 8'(b6); fb[7] = 8'(b7); fb[8] = 8'(b8); fb[9] = 8'(b9);
  endtask

  // driver: offers fb[0..n-1], in_last on the final byte when mark_last
  task automatic send_bytes(input int n, input bit mark_last);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = fb[i];
      in_last  = mark_last && (i == n - 1);
      t = 0;
      while (!in_ready && t < 50) begin
        step();
        t++;
      end
      check_val("in_ready_wait", 80'(in_ready), 80'd1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  // called one cycle after the last accept, with out_ready=1
  task automatic finish_frame(input int n, input logic [3:0] exp_cnt);
    logic [15:0] e_sum;
    e_sum = exp_q.pop_front();
    check_val("capture_ops_valid", 80'(ops_valid), 80'd1);
    check_val("capture_in_ready", 80'(in_ready), 80'd0);
    check_val("capture_out_valid", 80'(out_valid), 80'd0);
    check_val("capture_ops", ops, pack_ops(n));
    step();
    check_val("done_out_valid", 80'(out_valid), 80'd1);
    check_val("done_ops_valid", 80'(ops_valid), 80'd0);
    check_val("done_out_sum", 80'(out_sum), 80'(e_sum));
    check_val("done_out_count", 80'(out_count), 80'(exp_cnt));
    check_val("done_ops_held", ops, pack_ops(n));
    step();
    check_val("after_out_valid", 80'(out_valid), 80'd0);
    check_val("after_in_ready", 80'(in_ready), 80'd1);
    check_val("after_ops_clear", ops, 80'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_in_ready"}, 80'(in_ready), 80'd1);
    check_val({tag, "_ops_valid"}, 80'(ops_valid), 80'd0);
    check_val({tag, "_out_valid"}, 80'(out_valid), 80'd0);
    check_val({tag, "_ops"}, ops, 80'd0);
    check_val({tag, "_out_sum"}, 80'(out_sum), 80'd0);
    check_val({tag, "_out_count"}, 80'(out_count), 80'd0);
    check_val({tag, "_state"}, 80'(dbg_state), 80'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_reset_state("reset");

    // 1: full frame back to back
    fill_fb(11, 2, 13, 4, 5, 6, 7, 8, 9, 10);
    exp_q.push_back(16'd75);
    send_bytes(10, 1'b0);
    finish_frame(10, 4'd10);

    // 2: ten bytes with in_last on the tenth, then a short frame
    fill_fb(3, 14, 5, 6, 7, 8, 19, 10, 0, 0);
    exp_q.push_back(16'd72);
    send_bytes(10, 1'b1);
    finish_frame(10, 4'd10);
    fill_fb(200, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(16'd300);
    send_bytes(2, 1'b1);
    finish_frame(2, 4'd2);

    // 3: max values, then single zero byte
    fill_fb(255, 255, 255, 255, 255, 255, 255, 255, 255, 255);
    exp_q.push_back(16'd2550);
    send_bytes(10, 1'b0);
    finish_frame(10, 4'd10);
    fill_fb(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(16'd0);
    send_bytes(1, 1'b1);
    finish_frame(1, 4'd1);

    // 4: backpressure with the next frame's first byte waiting
    fill_fb(11, 2, 13, 4, 5, 6, 7, 8, 9, 10);
    out_ready = 1'b0;
    send_bytes(10, 1'b0);
    check_val("bp_ops_valid", 80'(ops_valid), 80'd1);
    step();
    in_valid = 1'b1;
    in_data  = fb[0];
    for (int c = 0; c < 5; c++) begin
      check_val("bp_out_valid", 80'(out_valid), 80'd1);
      check_val("bp_out_sum", 80'(out_sum), 80'd75);
      check_val("bp_out_count", 80'(out_count), 80'd10);
      check_val("bp_ops_held", ops, pack_ops(10));
      check_val("bp_in_ready", 80'(in_ready), 80'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check_val("bp_release_out_valid", 80'(out_valid), 80'd0);
    check_val("bp_release_ops", ops, 80'd0);
    exp_q.push_back(16'd75);
    send_bytes(10, 1'b0);
    finish_frame(10, 4'd10);

    // 5: flush mid-frame with a byte offered, then a clean frame
    fill_fb(1, 2, 3, 4, 0, 0, 0, 0, 0, 0);
    send_bytes(4, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'd50;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_in_ready", 80'(in_ready), 80'd1);
    check_val("flush_ops", ops, 80'd0);
    fill_fb(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    exp_q.push_back(16'd10);
    send_bytes(10, 1'b0);
    finish_frame(10, 4'd10);
    // flush while a result is held
    fill_fb(7, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    send_bytes(2, 1'b1);
    step();
    check_val("fdone_out_valid", 80'(out_valid), 80'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    check_val("fdone_out_valid_drop", 80'(out_valid), 80'd0);
    check_val("fdone_in_ready", 80'(in_ready), 80'd1);
    check_val("fdone_ops", ops, 80'd0);

    // 6: rst mid-frame and in CAPTURE
    fill_fb(9, 9, 9, 0, 0, 0, 0, 0, 0, 0);
    send_bytes(3, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst_mid");
    fill_fb(20, 30, 0, 0, 0, 0, 0, 0, 0, 0);
    send_bytes(2, 1'b1);
    check_val("rst_cap_ops_valid", 80'(ops_valid), 80'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst_cap");
    fill_fb(5, 6, 7, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(16'd18);
    send_bytes(3, 1'b1);
    finish_frame(3, 4'd3);

    check_val("exp_q_empty", 80'(exp_q.size()), 80'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
